// File: rtl/msrv32_lsu_pkg.sv
// rtl/msrv32_lsu_pkg.sv - shared encodings and width helpers for the load unit
package msrv32_lsu_pkg;

  typedef enum logic [1:0] {
    LS_BYTE  = 2'b00,
    LS_HALF  = 2'b01,
    LS_WORD  = 2'b10,
    LS_DWORD = 2'b11
  } ls_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_DONE  = 2'b11
  } lu_state_e;

  function automatic int bpw_of(input int xlen);
    return xlen / 8;
  endfunction

  function automatic int offw_of(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/msrv32_load_align_unit_if.sv
// rtl/msrv32_load_align_unit_if.sv - request, bus and result signals of the load unit
interface msrv32_load_align_unit_if #(
  parameter int XLEN = 32
);
  logic            ld_valid_in;
  logic            ld_ready_out;
  logic [XLEN-1:0] ld_addr_in;
  logic [1:0]      ld_size_in;
  logic            ld_unsigned_in;
  logic [4:0]      ld_rd_in;

  logic            bus_req_out;
  logic [XLEN-1:0] bus_addr_out;
  logic            bus_ready_in;
  logic            bus_err_in;
  logic [XLEN-1:0] bus_rdata_in;

  logic            lu_valid_out;
  logic [XLEN-1:0] lu_data_out;
  logic [4:0]      lu_rd_out;
  logic            lu_fault_out;

  // master: execute stage plus data bus; slave: the load unit itself
  modport master (
    output ld_valid_in, ld_addr_in, ld_size_in, ld_unsigned_in, ld_rd_in,
    output bus_ready_in, bus_err_in, bus_rdata_in,
    input  ld_ready_out, bus_req_out, bus_addr_out,
    input  lu_valid_out, lu_data_out, lu_rd_out, lu_fault_out
  );

  modport slave (
    input  ld_valid_in, ld_addr_in, ld_size_in, ld_unsigned_in, ld_rd_in,
    input  bus_ready_in, bus_err_in, bus_rdata_in,
    output ld_ready_out, bus_req_out, bus_addr_out,
    output lu_valid_out, lu_data_out, lu_rd_out, lu_fault_out
  );

endinterface

// File: rtl/msrv32_load_extract.sv
// rtl/msrv32_load_extract.sv - merges two beats, extracts the addressed field and extends it
module msrv32_load_extract
  import msrv32_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFFW = offw_of(XLEN)
) (
  input  logic [XLEN-1:0] beat0,
  input  logic [XLEN-1:0] beat1,
  input  logic [OFFW-1:0] off,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  localparam int NBW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] low;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] top;
  logic [NBW-1:0]  nbits;
  logic            sign;

  always_comb begin
    low   = XLEN'({beat1, beat0} >> {off, 3'b000});
    nbits = NBW'(8) << size;
    // shifting by the full width yields zero, so a full-width field gets an all-ones mask
    mask  = ~({XLEN{1'b1}} << nbits);
    top   = mask & ~(mask >> 1);
    sign  = (|(low & top)) & ~is_unsigned;
    result = (low & mask) | (sign ? ~mask : '0);
  end

endmodule

// File: rtl/msrv32_load_align_unit.sv
// rtl/msrv32_load_align_unit.sv - sequential load unit with beat splitting, wait states and faults
module msrv32_load_align_unit
  import msrv32_lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic                     ms_riscv32_mp_clk_in,
  input logic                     ms_riscv32_mp_rst_n_in,
  msrv32_load_align_unit_if.slave lu
);

  localparam int BPW  = bpw_of(XLEN);
  localparam int OFFW = offw_of(XLEN);
  localparam int SW   = OFFW + 3;

  lu_state_e       state;
  logic [OFFW-1:0] off_q;
  ls_size_e        size_q;
  logic            uns_q;
  logic [4:0]      rd_q;
  logic            cross_q;
  logic [XLEN-1:0] beat0_q;

  logic            bus_req;
  logic [XLEN-1:0] bus_addr;
  logic            lu_valid;
  logic [XLEN-1:0] lu_data;
  logic [4:0]      lu_rd;
  logic            lu_fault;

  logic [OFFW-1:0] req_off;
  logic            req_cross;
  logic            req_illegal;
  logic [XLEN-1:0] ex_beat0;
  logic [XLEN-1:0] ex_beat1;
  logic [XLEN-1:0] ex_result;

  always_comb begin
    req_off     = lu.ld_addr_in[OFFW-1:0];
    req_cross   = (SW'(req_off) + (SW'(1) << lu.ld_size_in)) > SW'(BPW);
    req_illegal = ((XLEN == 32) && (lu.ld_size_in == LS_DWORD)) ||
                  (req_cross && !MISALIGN_EN);
    // the beat completing this cycle feeds the extractor directly so the result registers on that edge
    ex_beat0    = (state == ST_BEAT1) ? beat0_q : lu.bus_rdata_in;
    ex_beat1    = (state == ST_BEAT1) ? lu.bus_rdata_in : '0;
  end

  msrv32_load_extract #(.XLEN(XLEN)) u_extract (
    .beat0       (ex_beat0),
    .beat1       (ex_beat1),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ex_result)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state    <= ST_IDLE;
      off_q    <= '0;
      size_q   <= LS_BYTE;
      uns_q    <= 1'b0;
      rd_q     <= '0;
      cross_q  <= 1'b0;
      beat0_q  <= '0;
      bus_req  <= 1'b0;
      bus_addr <= '0;
      lu_valid <= 1'b0;
      lu_data  <= '0;
      lu_rd    <= '0;
      lu_fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lu.ld_valid_in) begin
            off_q   <= req_off;
            size_q  <= ls_size_e'(lu.ld_size_in);
            uns_q   <= lu.ld_unsigned_in;
            rd_q    <= lu.ld_rd_in;
            cross_q <= req_cross;
            if (req_illegal) begin
              state    <= ST_DONE;
              lu_valid <= 1'b1;
              lu_fault <= 1'b1;
              lu_data  <= '0;
              lu_rd    <= lu.ld_rd_in;
            end else begin
              state    <= ST_BEAT0;
              bus_req  <= 1'b1;
              bus_addr <= {lu.ld_addr_in[XLEN-1:OFFW], OFFW'(0)};
            end
          end
        end
        ST_BEAT0: begin
          if (lu.bus_ready_in) begin
            beat0_q <= lu.bus_rdata_in;
            if (!lu.bus_err_in && cross_q) begin
              state    <= ST_BEAT1;
              bus_addr <= bus_addr + XLEN'(BPW);
            end else begin
              state    <= ST_DONE;
              bus_req  <= 1'b0;
              lu_valid <= 1'b1;
              lu_rd    <= rd_q;
              lu_fault <= lu.bus_err_in;
              lu_data  <= lu.bus_err_in ? '0 : ex_result;
            end
          end
        end
        ST_BEAT1: begin
          if (lu.bus_ready_in) begin
            state    <= ST_DONE;
            bus_req  <= 1'b0;
            lu_valid <= 1'b1;
            lu_rd    <= rd_q;
            lu_fault <= lu.bus_err_in;
            lu_data  <= lu.bus_err_in ? '0 : ex_result;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          lu_valid <= 1'b0;
          lu_data  <= '0;
          lu_fault <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign lu.ld_ready_out = (state == ST_IDLE);
  assign lu.bus_req_out  = bus_req;
  assign lu.bus_addr_out = bus_addr;
  assign lu.lu_valid_out = lu_valid;
  assign lu.lu_data_out  = lu_data;
  assign lu.lu_rd_out    = lu_rd;
  assign lu.lu_fault_out = lu_fault;

endmodule

// File: tb/tb_msrv32_load_align_unit.sv
// tb/tb_msrv32_load_align_unit.sv - directed bench over 32-bit, 32-bit strict and 64-bit load units
module tb_msrv32_load_align_unit;
  import msrv32_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  int          sel;
  logic        drv_valid;
  logic [63:0] drv_addr;
  logic [1:0]  drv_size;
  logic        drv_uns;
  logic [4:0]  drv_rd;
  logic        drv_ready;
  logic        drv_err;
  logic [63:0] drv_rdata;

  msrv32_load_align_unit_if #(.XLEN(32)) ifa ();
  msrv32_load_align_unit_if #(.XLEN(32)) ifb ();
  msrv32_load_align_unit_if #(.XLEN(64)) ifc ();

  msrv32_load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) dut_a (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .lu                     (ifa)
  );
  msrv32_load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) dut_b (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .lu                     (ifb)
  );
  msrv32_load_align_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) dut_c (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .lu                     (ifc)
  );

  assign ifa.ld_valid_in    = drv_valid && (sel == 0);
  assign ifb.ld_valid_in    = drv_valid && (sel == 1);
  assign ifc.ld_valid_in    = drv_valid && (sel == 2);
  assign ifa.ld_addr_in     = drv_addr[31:0];
  assign ifb.ld_addr_in     = drv_addr[31:0];
  assign ifc.ld_addr_in     = drv_addr;
  assign ifa.ld_size_in     = drv_size;
  assign ifb.ld_size_in     = drv_size;
  assign ifc.ld_size_in     = drv_size;
  assign ifa.ld_unsigned_in = drv_uns;
  assign ifb.ld_unsigned_in = drv_uns;
  assign ifc.ld_unsigned_in = drv_uns;
  assign ifa.ld_rd_in       = drv_rd;
  assign ifb.ld_rd_in       = drv_rd;
  assign ifc.ld_rd_in       = drv_rd;
  assign ifa.bus_ready_in   = drv_ready;
  assign ifb.bus_ready_in   = drv_ready;
  assign ifc.bus_ready_in   = drv_ready;
  assign ifa.bus_err_in     = drv_err;
  assign ifb.bus_err_in     = drv_err;
  assign ifc.bus_err_in     = drv_err;
  assign ifa.bus_rdata_in   = drv_rdata[31:0];
  assign ifb.bus_rdata_in   = drv_rdata[31:0];
  assign ifc.bus_rdata_in   = drv_rdata;

  logic        o_ready, o_req, o_valid, o_fault;
  logic [63:0] o_addr, o_data;
  logic [4:0]  o_rd;

  always_comb begin
    o_ready = ifa.ld_ready_out;
    o_req   = ifa.bus_req_out;
    o_addr  = {32'h0, ifa.bus_addr_out};
    o_valid = ifa.lu_valid_out;
    o_data  = {32'h0, ifa.lu_data_out};
    o_rd    = ifa.lu_rd_out;
    o_fault = ifa.lu_fault_out;
    if (sel == 1) begin
      o_ready = ifb.ld_ready_out;
      o_req   = ifb.bus_req_out;
      o_addr  = {32'h0, ifb.bus_addr_out};
      o_valid = ifb.lu_valid_out;
      o_data  = {32'h0, ifb.lu_data_out};
      o_rd    = ifb.lu_rd_out;
      o_fault = ifb.lu_fault_out;
    end else if (sel == 2) begin
      o_ready = ifc.ld_ready_out;
      o_req   = ifc.bus_req_out;
      o_addr  = ifc.bus_addr_out;
      o_valid = ifc.lu_valid_out;
      o_data  = ifc.lu_data_out;
      o_rd    = ifc.lu_rd_out;
      o_fault = ifc.lu_fault_out;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge after the accepting edge.
  task automatic req(input string tag, input int d, input logic [63:0] a, input logic [1:0] s,
                     input logic u, input logic [4:0] r);
    sel = d;
    #1;
    chk({tag, ".ld_ready"}, {63'h0, o_ready}, 64'h1);
    drv_addr  = a;
    drv_size  = s;
    drv_uns   = u;
    drv_rd    = r;
    drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  // Check the outstanding beat, hold it for some wait cycles, then complete it.
  task automatic beat(input string tag, input logic [63:0] a, input logic [63:0] data,
                      input logic e, input int waits);
    chk({tag, ".req"},  {63'h0, o_req}, 64'h1);
    chk({tag, ".addr"}, o_addr, a);
    for (int i = 0; i < waits; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".hold_req"},   {63'h0, o_req}, 64'h1);
      chk({tag, ".hold_addr"},  o_addr, a);
      chk({tag, ".hold_valid"}, {63'h0, o_valid}, 64'h0);
    end
    drv_ready = 1'b1;
    drv_rdata = data;
    drv_err   = e;
    @(posedge clk);
    @(negedge clk);
    drv_ready = 1'b0;
    drv_err   = 1'b0;
    drv_rdata = 64'h0;
  endtask

  // Expect the result pulse now, and its retirement one cycle later.
  task automatic result(input string tag, input logic [63:0] data, input logic [4:0] r, input logic f);
    chk({tag, ".valid"},    {63'h0, o_valid}, 64'h1);
    chk({tag, ".data"},     o_data, data);
    chk({tag, ".rd"},       {59'h0, o_rd}, {59'h0, r});
    chk({tag, ".fault"},    {63'h0, o_fault}, {63'h0, f});
    chk({tag, ".req_done"}, {63'h0, o_req}, 64'h0);
    chk({tag, ".busy"},     {63'h0, o_ready}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid_off"}, {63'h0, o_valid}, 64'h0);
    chk({tag, ".data_off"},  o_data, 64'h0);
    chk({tag, ".fault_off"}, {63'h0, o_fault}, 64'h0);
    chk({tag, ".rd_hold"},   {59'h0, o_rd}, {59'h0, r});
    chk({tag, ".idle"},      {63'h0, o_ready}, 64'h1);
    chk({tag, ".req_off"},   {63'h0, o_req}, 64'h0);
  endtask

  initial begin
    sel       = 0;
    drv_valid = 1'b0;
    drv_addr  = 64'h0;
    drv_size  = 2'b00;
    drv_uns   = 1'b0;
    drv_rd    = 5'd0;
    drv_ready = 1'b0;
    drv_err   = 1'b0;
    drv_rdata = 64'h0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      chk("rst.ready", {63'h0, o_ready}, 64'h1);
      chk("rst.req",   {63'h0, o_req}, 64'h0);
      chk("rst.addr",  o_addr, 64'h0);
      chk("rst.valid", {63'h0, o_valid}, 64'h0);
      chk("rst.data",  o_data, 64'h0);
      chk("rst.rd",    {59'h0, o_rd}, 64'h0);
      chk("rst.fault", {63'h0, o_fault}, 64'h0);
    end

    req("lw100", 0, 64'h100, LS_WORD, 1'b0, 5'd7);
    beat("lw100.b0", 64'h100, 64'hDEADBEEF, 1'b0, 0);
    result("lw100", 64'hDEADBEEF, 5'd7, 1'b0);

    req("lb103", 0, 64'h103, LS_BYTE, 1'b0, 5'd3);
    beat("lb103.b0", 64'h100, 64'h80123456, 1'b0, 0);
    result("lb103", 64'hFFFFFF80, 5'd3, 1'b0);
    req("lbu103", 0, 64'h103, LS_BYTE, 1'b1, 5'd4);
    beat("lbu103.b0", 64'h100, 64'h80123456, 1'b0, 0);
    result("lbu103", 64'h00000080, 5'd4, 1'b0);
    req("lhu102", 0, 64'h102, LS_HALF, 1'b1, 5'd5);
    beat("lhu102.b0", 64'h100, 64'h80123456, 1'b0, 0);
    result("lhu102", 64'h00008012, 5'd5, 1'b0);
    req("lh102", 0, 64'h102, LS_HALF, 1'b0, 5'd6);
    beat("lh102.b0", 64'h100, 64'h80123456, 1'b0, 0);
    result("lh102", 64'hFFFF8012, 5'd6, 1'b0);

    req("lwffe", 0, 64'hFFE, LS_WORD, 1'b0, 5'd9);
    beat("lwffe.b0", 64'hFFC, 64'h11223344, 1'b0, 0);
    beat("lwffe.b1", 64'h1000, 64'h55667788, 1'b0, 0);
    result("lwffe", 64'h77881122, 5'd9, 1'b0);

    req("strict.lwffe", 1, 64'hFFE, LS_WORD, 1'b0, 5'd10);
    result("strict.lwffe", 64'h0, 5'd10, 1'b1);

    req("ld32", 0, 64'h100, LS_DWORD, 1'b0, 5'd11);
    result("ld32", 64'h0, 5'd11, 1'b1);

    req("lwwait", 0, 64'h200, LS_WORD, 1'b0, 5'd12);
    beat("lwwait.b0", 64'h200, 64'h0BADF00D, 1'b0, 3);
    result("lwwait", 64'h0BADF00D, 5'd12, 1'b0);

    req("lwerr", 0, 64'h1FE, LS_WORD, 1'b0, 5'd13);
    beat("lwerr.b0", 64'h1FC, 64'h12345678, 1'b1, 0);
    result("lwerr", 64'h0, 5'd13, 1'b1);

    req("lwwrap", 0, 64'hFFFFFFFE, LS_WORD, 1'b0, 5'd14);
    beat("lwwrap.b0", 64'hFFFFFFFC, 64'hAABBCCDD, 1'b0, 0);
    beat("lwwrap.b1", 64'h0, 64'h11223344, 1'b0, 0);
    result("lwwrap", 64'h3344AABB, 5'd14, 1'b0);

    req("ld8", 2, 64'h8, LS_DWORD, 1'b0, 5'd15);
    beat("ld8.b0", 64'h8, 64'h8000000000000001, 1'b0, 0);
    result("ld8", 64'h8000000000000001, 5'd15, 1'b0);
    req("lwc", 2, 64'hC, LS_WORD, 1'b0, 5'd16);
    beat("lwc.b0", 64'h8, 64'h8000000000000001, 1'b0, 0);
    result("lwc", 64'hFFFFFFFF80000000, 5'd16, 1'b0);

    req("rststall", 2, 64'h10, LS_WORD, 1'b0, 5'd17);
    chk("rststall.req", {63'h0, o_req}, 64'h1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rststall.req_drop", {63'h0, o_req}, 64'h0);
    chk("rststall.ready",    {63'h0, o_ready}, 64'h1);
    chk("rststall.valid",    {63'h0, o_valid}, 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rststall.no_valid", {63'h0, o_valid}, 64'h0);
      chk("rststall.no_req",   {63'h0, o_req}, 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/msrv32_load_align_unit.md
# msrv32_load_align_unit

Sequential, parametrised load unit between the execute stage and the data-side AHB-style bus. It accepts one load request at a time and splits misaligned accesses that cross a bus word into two aligned beats. It then merges, extracts and sign/zero-extends the result and returns it with its destination-register tag. It supersedes the combinational byte/half extractor and adds XLEN=64 (doubleword), wait-state handling, bus-error faults and misaligned-load support.

## Interface
Parameters:
- XLEN, 32: data and address width. Legal values are 32 and 64. BPW = XLEN/8 bytes per bus word; OFFW = log2(BPW).
- MISALIGN_EN, 1: 1 splits a word-crossing load into two beats; 0 faults on it.

Ports:
- ms_riscv32_mp_clk_in  in  1  single clock. Everything is on the rising edge.
- ms_riscv32_mp_rst_n_in  in  1  reset, synchronous, active-low.
- ld_valid_in  in  1  load request valid.
- ld_ready_out  out  1  unit can accept a request; high only in IDLE.
- ld_addr_in  in  XLEN  byte address.
- ld_size_in  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when XLEN=64).
- ld_unsigned_in  in  1  1 zero-extends, 0 sign-extends.
- ld_rd_in  in  5  destination tag.
- bus_req_out  out  1  bus beat request.
- bus_addr_out  out  XLEN  beat address; low OFFW bits are always 0.
- bus_ready_in  in  1  beat complete (HREADY).
- bus_err_in  in  1  error response; qualified by bus_ready_in.
- bus_rdata_in  in  XLEN  beat read data, valid when bus_ready_in=1.
- lu_valid_out  out  1  result valid, exactly one-cycle pulse.
- lu_data_out  out  XLEN  extended load result.
- lu_rd_out  out  5  tag of the returned load.
- lu_fault_out  out  1  load faulted; qualified by lu_valid_out.

## Operation
States: IDLE, BEAT0, BEAT1, DONE. All outputs are registered except ld_ready_out, which is decoded from state.

- Reset values: state IDLE, ld_ready_out=1, bus_req_out=0, bus_addr_out=0, lu_valid_out=0, lu_data_out=0, lu_rd_out=0, lu_fault_out=0.
- Accept (IDLE, ld_valid_in=1):
  - Latch addr, size, unsigned and rd.
  - off = addr[OFFW-1:0], nbytes = 1<<size, cross = (off+nbytes > BPW).
- Illegal request: size=11 with XLEN=32, or cross with MISALIGN_EN=0. Go IDLE→DONE with fault=1 and data 0. No bus beat is issued.
- IDLE→BEAT0: bus_req_out=1, bus_addr_out = addr with the low OFFW bits cleared.
- Beat hold rule: bus_req_out and bus_addr_out stay stable until a cycle with bus_ready_in=1. bus_rdata_in is captured in that cycle.
- Leaving BEAT0 on bus_ready_in=1:
  - bus_err_in=1 → DONE, fault=1, data 0. BEAT1 is never issued.
  - cross=1 → BEAT1, bus_addr_out = aligned addr + BPW. The addition is modulo 2^XLEN, so the top word wraps to 0.
  - otherwise → DONE.
- BEAT1 completes the same way as BEAT0, then goes to DONE. An error in BEAT1 faults.
- Merge: form {beat1, beat0} (2·XLEN bits; beat1 = 0 when there is no crossing) and shift right by off·8. Take the low nbytes·8 bits. Extend: sign from the top extracted bit, or zero if unsigned.
- DONE: lu_valid_out=1 for one cycle with data, rd and fault, then IDLE. lu_data_out and lu_fault_out return to 0 in the cycle after DONE; lu_rd_out holds.
- Reset mid-operation: the next edge forces IDLE. bus_req_out drops, no lu_valid_out is generated, and any pending beat is abandoned.

## Timing
Request accepted at edge T:
- Aligned load, zero wait: bus_req_out is high in cycle T+1 and lu_valid_out is high at T+2.
- Crossing load, zero wait: lu_valid_out is high at T+3.
- Each wait cycle (bus_ready_in=0) adds one cycle.
- Illegal request: lu_valid_out is high at T+1, with no bus_req_out.
- Throughput: one load per (latency+1) cycles, because ld_ready_out is low from BEAT0 through DONE.

## Structure
- Package msrv32_lsu_pkg holds:
  - size encodings (LS_BYTE, LS_HALF, LS_WORD, LS_DWORD);
  - the state encoding;
  - functions deriving BPW and OFFW from XLEN.
- Sub-module msrv32_load_extract: combinational merge, shift and extend, parametrised by XLEN. Inputs: beat0, beat1, off, size, unsigned. Output: XLEN-bit result.
- The top level holds the FSM, the request latches and the beat-data registers.

## Test plan
1. XLEN=32, LW at 0x100, rd=7; rdata 0xDEADBEEF, bus_ready_in=1 → one beat at 0x100; lu_valid_out at T+2 with data 0xDEADBEEF, rd=7, fault=0.
2. LB at 0x103 with rdata 0x80123456 → 0xFFFFFF80; LBU at the same address → 0x00000080; LHU at 0x102 → 0x00008012.
3. LW at 0xFFE, MISALIGN_EN=1: beat0 at 0xFFC returns 0x11223344, beat1 at 0x1000 returns 0x55667788 → data 0x77881122 at T+3. With MISALIGN_EN=0 → fault at T+1, no bus_req_out.
4. Aligned LW with bus_ready_in low for 3 cycles → bus_req_out and bus_addr_out held constant; lu_valid_out at T+5; exactly one pulse.
5. Crossing LW with bus_err_in=1 on beat0 → fault=1, data 0; no beat at +4. Then LW at 0xFFFFFFFE → beat1 address 0x00000000.
6. XLEN=64, LD at 0x8 with rdata 0x8000000000000001 → same value; LW at 0xC → 0xFFFFFFFF80000000. Then reset asserted during a stalled BEAT0 → bus_req_out=0 and ld_ready_out=1 after the edge, no lu_valid_out.
